// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared definitions for the fetch redirect controller.
//   state_t  : controller FSM states (BOOT, RUN, MISS, BUBBLE)
//   src_t    : source of the most recent PC load (SEQ, BTB, ID, EX)
//   FETCH_STRIDE : byte advance of one sequential fetch bundle
//   ALIGN_BITS   : low PC bits cleared on every loaded redirect target
package fetch_redirect_ctrl_pkg;

    localparam int FETCH_BANDWIDTH = 4;
    localparam int INST_BYTES      = 8;
    localparam int FETCH_STRIDE    = FETCH_BANDWIDTH * INST_BYTES;
    localparam int ALIGN_BITS      = $clog2(INST_BYTES);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        MISS   = 2'd2,
        BUBBLE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SRC_SEQ = 2'd0,
        SRC_BTB = 2'd1,
        SRC_ID  = 2'd2,
        SRC_EX  = 2'd3
    } src_t;

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// Bus between the fetch redirect controller and the surrounding pipeline.
//   Inputs to the controller : stall/queue-full, EX and ID redirects with
//                              targets, BTB prediction, I-cache miss/fill.
//   Outputs from controller  : fetch PC, stage-1 valid, flush and cancel
//                              pulses, redirect source.
//   master : pipeline side (drives the requests, observes the PC)
//   slave  : controller side
interface fetch_redirect_ctrl_if #(
    parameter int SIZE_PC = 32
);
    logic               stall_i;
    logic               ctiQueueFull_i;
    logic               recoverEX_i;
    logic [SIZE_PC-1:0] targetEX_i;
    logic               recoverID_i;
    logic [SIZE_PC-1:0] targetID_i;
    logic               btbTaken_i;
    logic [SIZE_PC-1:0] btbTarget_i;
    logic               icacheMiss_i;
    logic               icacheFill_i;

    logic [SIZE_PC-1:0] pc_o;
    logic               fs1Ready_o;
    logic               flushFS_o;
    logic               icacheCancel_o;
    logic [1:0]         redirectSrc_o;

    modport master (
        output stall_i, ctiQueueFull_i, recoverEX_i, targetEX_i,
               recoverID_i, targetID_i, btbTaken_i, btbTarget_i,
               icacheMiss_i, icacheFill_i,
        input  pc_o, fs1Ready_o, flushFS_o, icacheCancel_o, redirectSrc_o
    );

    modport slave (
        input  stall_i, ctiQueueFull_i, recoverEX_i, targetEX_i,
               recoverID_i, targetID_i, btbTaken_i, btbTarget_i,
               icacheMiss_i, icacheFill_i,
        output pc_o, fs1Ready_o, flushFS_o, icacheCancel_o, redirectSrc_o
    );
endinterface

// File: rtl/fetch_redirect_ctrl_next_pc_mux.sv
// Combinational next-PC priority select for the RUN state.
//   pc, cur_src          : current fetch PC and redirect source
//   recover_ex/target_ex : execute-stage redirect (highest priority)
//   recover_id/target_id : decode-stage redirect
//   hold                 : stall or CTI queue full, keep PC and source
//   miss                 : I-cache miss, keep PC (caller enters MISS)
//   btb_taken/btb_target : predicted-taken redirect
//   next_pc, next_src    : selected PC and source
//   sel_ex, sel_id, sel_miss : which rule won
//   ex_pc                : aligned EX target, used outside RUN as well
module fetch_redirect_ctrl_next_pc_mux
    import fetch_redirect_ctrl_pkg::*;
#(
    parameter int SIZE_PC = 32
) (
    input  logic [SIZE_PC-1:0] pc,
    input  src_t               cur_src,
    input  logic               recover_ex,
    input  logic [SIZE_PC-1:0] target_ex,
    input  logic               recover_id,
    input  logic [SIZE_PC-1:0] target_id,
    input  logic               hold,
    input  logic               miss,
    input  logic               btb_taken,
    input  logic [SIZE_PC-1:0] btb_target,
    output logic [SIZE_PC-1:0] next_pc,
    output src_t               next_src,
    output logic               sel_ex,
    output logic               sel_id,
    output logic               sel_miss,
    output logic [SIZE_PC-1:0] ex_pc
);

    function automatic logic [SIZE_PC-1:0] align(input logic [SIZE_PC-1:0] t);
        return {t[SIZE_PC-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
    endfunction

    assign ex_pc = align(target_ex);

    always_comb begin
        next_pc  = pc;
        next_src = cur_src;
        sel_ex   = 1'b0;
        sel_id   = 1'b0;
        sel_miss = 1'b0;
        if (recover_ex) begin
            next_pc  = ex_pc;
            next_src = SRC_EX;
            sel_ex   = 1'b1;
        end else if (recover_id) begin
            next_pc  = align(target_id);
            next_src = SRC_ID;
            sel_id   = 1'b1;
        end else if (hold) begin
            next_pc  = pc;
        end else if (miss) begin
            sel_miss = 1'b1;
        end else if (btb_taken) begin
            next_pc  = align(btb_target);
            next_src = SRC_BTB;
        end else begin
            // Sequential advance wraps naturally at 2^SIZE_PC.
            next_pc  = pc + SIZE_PC'(FETCH_STRIDE);
            next_src = SRC_SEQ;
        end
    end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect controller: owns the fetch PC, arbitrates redirects,
// holds on stall/miss and inserts a fetch bubble after an EX recovery.
//   clk   : clock, all state updates on the rising edge
//   reset : asynchronous, active-low
//   bus   : fetch_redirect_ctrl_if.slave (requests in, PC/pulses out)
module fetch_redirect_ctrl
    import fetch_redirect_ctrl_pkg::*;
#(
    parameter int              SIZE_PC        = 32,
    parameter logic [SIZE_PC-1:0] RESET_PC    = 32'h0000_2000,
    parameter int              RECOVER_BUBBLE = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    fetch_redirect_ctrl_if.slave  bus
);

    state_t             state_q, state_d;
    logic [SIZE_PC-1:0] pc_q, pc_d;
    src_t               src_q, src_d;
    logic [2:0]         cnt_q, cnt_d;
    logic               flush_q, flush_d;
    logic               cancel_q, cancel_d;
    logic               fs1_ready;

    logic [SIZE_PC-1:0] mux_pc;
    src_t               mux_src;
    logic               sel_ex, sel_id, sel_miss;
    logic [SIZE_PC-1:0] ex_pc;

    fetch_redirect_ctrl_next_pc_mux #(.SIZE_PC(SIZE_PC)) u_next_pc_mux (
        .pc         (pc_q),
        .cur_src    (src_q),
        .recover_ex (bus.recoverEX_i),
        .target_ex  (bus.targetEX_i),
        .recover_id (bus.recoverID_i),
        .target_id  (bus.targetID_i),
        .hold       (bus.stall_i | bus.ctiQueueFull_i),
        .miss       (bus.icacheMiss_i),
        .btb_taken  (bus.btbTaken_i),
        .btb_target (bus.btbTarget_i),
        .next_pc    (mux_pc),
        .next_src   (mux_src),
        .sel_ex     (sel_ex),
        .sel_id     (sel_id),
        .sel_miss   (sel_miss),
        .ex_pc      (ex_pc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            src_q    <= SRC_SEQ;
            cnt_q    <= 3'd0;
            flush_q  <= 1'b0;
            cancel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            src_q    <= src_d;
            cnt_q    <= cnt_d;
            flush_q  <= flush_d;
            cancel_q <= cancel_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        src_d     = src_q;
        cnt_d     = cnt_q;
        flush_d   = 1'b0;
        cancel_d  = 1'b0;
        fs1_ready = 1'b0;

        // An EX recovery from any active state enters the bubble; with a
        // zero-length bubble it resumes fetching directly.
        if (state_q != BOOT && bus.recoverEX_i) begin
            if (RECOVER_BUBBLE == 0) begin
                state_d = RUN;
                cnt_d   = 3'd0;
            end else begin
                state_d = BUBBLE;
                cnt_d   = 3'(RECOVER_BUBBLE);
            end
        end

        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                fs1_ready = ~bus.stall_i & ~bus.ctiQueueFull_i & ~bus.icacheMiss_i;
                pc_d      = mux_pc;
                src_d     = mux_src;
                flush_d   = sel_ex | sel_id;
                if (sel_miss) state_d = MISS;
            end
            MISS: begin
                // Recovery beats a simultaneous fill; the outstanding miss
                // is abandoned.
                if (bus.recoverEX_i) begin
                    pc_d     = ex_pc;
                    src_d    = SRC_EX;
                    flush_d  = 1'b1;
                    cancel_d = 1'b1;
                end else if (bus.icacheFill_i) begin
                    state_d = RUN;
                end
            end
            BUBBLE: begin
                if (bus.recoverEX_i) begin
                    pc_d    = ex_pc;
                    src_d   = SRC_EX;
                    flush_d = 1'b1;
                end else if (cnt_q <= 3'd1) begin
                    state_d = RUN;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign bus.pc_o           = pc_q;
    assign bus.fs1Ready_o     = fs1_ready;
    assign bus.flushFS_o      = flush_q;
    assign bus.icacheCancel_o = cancel_q;
    assign bus.redirectSrc_o  = src_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl.
module tb_fetch_redirect_ctrl;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    fetch_redirect_ctrl_if #(.SIZE_PC(32)) bus ();

    fetch_redirect_ctrl #(
        .SIZE_PC        (32),
        .RESET_PC       (32'h0000_2000),
        .RECOVER_BUBBLE (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.stall_i        = 1'b0;
        bus.ctiQueueFull_i = 1'b0;
        bus.recoverEX_i    = 1'b0;
        bus.targetEX_i     = '0;
        bus.recoverID_i    = 1'b0;
        bus.targetID_i     = '0;
        bus.btbTaken_i     = 1'b0;
        bus.btbTarget_i    = '0;
        bus.icacheMiss_i   = 1'b0;
        bus.icacheFill_i   = 1'b0;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b0;
        step();
        step();
        // Reset state
        chk("rst_pc", bus.pc_o, 32'h2000);
        chk("rst_fs1", 32'(bus.fs1Ready_o), 0);
        chk("rst_flush", 32'(bus.flushFS_o), 0);
        chk("rst_cancel", 32'(bus.icacheCancel_o), 0);
        chk("rst_src", 32'(bus.redirectSrc_o), 0);

        reset = 1'b1;
        #1;
        chk("boot_fs1", 32'(bus.fs1Ready_o), 0);
        step();
        chk("run0_fs1", 32'(bus.fs1Ready_o), 1);
        chk("run0_pc", bus.pc_o, 32'h2000);
        step(); chk("seq1_pc", bus.pc_o, 32'h2020);
        step(); chk("seq2_pc", bus.pc_o, 32'h2040);
        step(); chk("seq3_pc", bus.pc_o, 32'h2060);
        chk("seq_src", 32'(bus.redirectSrc_o), 0);

        // BTB taken, target low bits dropped
        bus.btbTaken_i = 1'b1; bus.btbTarget_i = 32'h3004;
        step();
        chk("btb_pc", bus.pc_o, 32'h3000);
        chk("btb_src", 32'(bus.redirectSrc_o), 1);
        clear_inputs();
        bus.stall_i = 1'b1;
        #1 chk("stall_fs1", 32'(bus.fs1Ready_o), 0);
        step(); chk("stall1_pc", bus.pc_o, 32'h3000);
        step(); chk("stall2_pc", bus.pc_o, 32'h3000);
        chk("stall_src", 32'(bus.redirectSrc_o), 1);
        bus.stall_i = 1'b0; bus.ctiQueueFull_i = 1'b1;
        #1 chk("cti_fs1", 32'(bus.fs1Ready_o), 0);
        step(); chk("cti_pc", bus.pc_o, 32'h3000);
        bus.ctiQueueFull_i = 1'b0;
        #1 chk("free_fs1", 32'(bus.fs1Ready_o), 1);
        step(); chk("free_pc", bus.pc_o, 32'h3020);

        // EX and ID together under stall: EX wins, bubble of 2
        bus.recoverEX_i = 1'b1; bus.targetEX_i = 32'h4000;
        bus.recoverID_i = 1'b1; bus.targetID_i = 32'h5000;
        bus.stall_i = 1'b1;
        step();
        clear_inputs();
        #1;
        chk("ex_pc", bus.pc_o, 32'h4000);
        chk("ex_src", 32'(bus.redirectSrc_o), 3);
        chk("ex_flush", 32'(bus.flushFS_o), 1);
        chk("bub1_fs1", 32'(bus.fs1Ready_o), 0);
        step();
        chk("ex_flush_end", 32'(bus.flushFS_o), 0);
        chk("bub2_fs1", 32'(bus.fs1Ready_o), 0);
        chk("bub2_pc", bus.pc_o, 32'h4000);
        step();
        chk("postbub_fs1", 32'(bus.fs1Ready_o), 1);
        chk("postbub_pc", bus.pc_o, 32'h4000);
        step(); chk("postbub_seq", bus.pc_o, 32'h4020);

        // ID redirect alone
        bus.recoverID_i = 1'b1; bus.targetID_i = 32'h5007;
        step();
        clear_inputs();
        #1;
        chk("id_pc", bus.pc_o, 32'h5000);
        chk("id_src", 32'(bus.redirectSrc_o), 2);
        chk("id_flush", 32'(bus.flushFS_o), 1);
        chk("id_fs1", 32'(bus.fs1Ready_o), 1);
        step(); chk("id_seq", bus.pc_o, 32'h5020);

        // I-cache miss, ID ignored in MISS, then fill
        bus.icacheMiss_i = 1'b1;
        #1 chk("miss_fs1_run", 32'(bus.fs1Ready_o), 0);
        step();
        clear_inputs();
        bus.recoverID_i = 1'b1; bus.targetID_i = 32'h7000;
        #1 chk("miss_fs1", 32'(bus.fs1Ready_o), 0);
        step();
        clear_inputs();
        #1;
        chk("miss_id_pc", bus.pc_o, 32'h5020);
        chk("miss_id_flush", 32'(bus.flushFS_o), 0);
        step(); step(); step();
        chk("miss_hold_pc", bus.pc_o, 32'h5020);
        bus.icacheFill_i = 1'b1;
        step();
        clear_inputs();
        #1;
        chk("fill_pc", bus.pc_o, 32'h5020);
        chk("fill_fs1", 32'(bus.fs1Ready_o), 1);
        chk("fill_cancel", 32'(bus.icacheCancel_o), 0);
        step(); chk("fill_seq", bus.pc_o, 32'h5040);

        // Miss then EX recovery with simultaneous fill
        bus.icacheMiss_i = 1'b1;
        step();
        clear_inputs();
        bus.recoverEX_i = 1'b1; bus.targetEX_i = 32'h6000; bus.icacheFill_i = 1'b1;
        step();
        clear_inputs();
        #1;
        chk("mex_pc", bus.pc_o, 32'h6000);
        chk("mex_src", 32'(bus.redirectSrc_o), 3);
        chk("mex_cancel", 32'(bus.icacheCancel_o), 1);
        chk("mex_flush", 32'(bus.flushFS_o), 1);
        chk("mex_fs1", 32'(bus.fs1Ready_o), 0);
        step();
        chk("mex_cancel_end", 32'(bus.icacheCancel_o), 0);
        chk("mex_bub2_fs1", 32'(bus.fs1Ready_o), 0);
        step();
        chk("mex_run_fs1", 32'(bus.fs1Ready_o), 1);

        // EX recovery inside BUBBLE reloads PC and counter
        bus.recoverEX_i = 1'b1; bus.targetEX_i = 32'h7000;
        step();
        clear_inputs();
        bus.recoverEX_i = 1'b1; bus.targetEX_i = 32'h7100;
        bus.recoverID_i = 1'b1; bus.targetID_i = 32'h9900;
        bus.btbTaken_i = 1'b1; bus.btbTarget_i = 32'h9000;
        step();
        clear_inputs();
        #1;
        chk("rebub_pc", bus.pc_o, 32'h7100);
        chk("rebub_flush", 32'(bus.flushFS_o), 1);
        chk("rebub_fs1", 32'(bus.fs1Ready_o), 0);
        step();
        chk("rebub2_fs1", 32'(bus.fs1Ready_o), 0);
        step();
        chk("rebub_run_fs1", 32'(bus.fs1Ready_o), 1);
        chk("rebub_run_pc", bus.pc_o, 32'h7100);

        // Sequential wrap at the top of the address space
        bus.recoverEX_i = 1'b1; bus.targetEX_i = 32'hFFFF_FFE5;
        step();
        clear_inputs();
        step(); step();
        chk("wrap_top_pc", bus.pc_o, 32'hFFFF_FFE0);
        step();
        chk("wrap_pc", bus.pc_o, 32'h0000_0000);
        chk("wrap_src", 32'(bus.redirectSrc_o), 0);

        // Asynchronous reset in the middle of BUBBLE
        bus.recoverEX_i = 1'b1; bus.targetEX_i = 32'h8000;
        step();
        clear_inputs();
        #2 reset = 1'b0;
        #1;
        chk("bubrst_pc", bus.pc_o, 32'h2000);
        chk("bubrst_flush", 32'(bus.flushFS_o), 0);
        chk("bubrst_cancel", 32'(bus.icacheCancel_o), 0);
        chk("bubrst_src", 32'(bus.redirectSrc_o), 0);

        // Asynchronous reset in the middle of MISS: no cancel pulse
        step();
        reset = 1'b1;
        step();
        bus.icacheMiss_i = 1'b1;
        step();
        bus.recoverEX_i = 1'b1; bus.targetEX_i = 32'hA000;
        #2 reset = 1'b0;
        #1;
        step();
        clear_inputs();
        chk("missrst_cancel", 32'(bus.icacheCancel_o), 0);
        chk("missrst_pc", bus.pc_o, 32'h2000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
- Owns the fetch PC register and sequences fetch stage 1 and the fetch stage 2 pre-decode/BTB-validation datapath.
- Each cycle it arbitrates the next fetch PC between the following sources:
  - execute-stage recovery (flagRecoverEX), highest priority;
  - decode-stage recovery (flagRecoverID from FetchStage2);
  - a BTB-predicted taken target;
  - sequential increment, lowest priority.
- It holds the PC on stall, CTI-queue-full or I-cache miss.
- It inserts a fixed fetch bubble after an execute-stage recovery.

Parameters:
- SIZE_PC, 32, PC width in bits.
- FETCH_BANDWIDTH, 4, instructions per fetch bundle.
- INST_BYTES, 8, byte stride per instruction. Sequential increment = FETCH_BANDWIDTH*INST_BYTES = 32.
- RESET_PC, 32'h0000_2000, first fetch address after reset.
- RECOVER_BUBBLE, 2, fetch-suppressed cycles after an EX recovery (legal range 0..7).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall_i  in  1  backend stall; hold PC, no fetch.
- ctiQueueFull_i  in  1  CTI queue full; same effect as stall_i.
- recoverEX_i  in  1  execute-stage mispredict redirect.
- targetEX_i  in  SIZE_PC  execute-stage redirect target.
- recoverID_i  in  1  decode-stage redirect (already gated by stall in FetchStage2).
- targetID_i  in  SIZE_PC  decode-stage redirect target.
- btbTaken_i  in  1  BTB hit with taken prediction for the current bundle.
- btbTarget_i  in  SIZE_PC  BTB target.
- icacheMiss_i  in  1  current fetch missed in the I-cache.
- icacheFill_i  in  1  one-cycle pulse when the fill completes.
- pc_o  out  SIZE_PC  registered fetch PC.
- fs1Ready_o  out  1  fetch stage 1 output valid this cycle.
- flushFS_o  out  1  one-cycle pulse that kills the in-flight fetch stage 1/2 bundles.
- icacheCancel_o  out  1  one-cycle pulse that abandons an outstanding miss.
- redirectSrc_o  out  2  source of the last PC load: 0=seq, 1=BTB, 2=ID, 3=EX.

Behaviour:
- Reset (reset low, asynchronous):
  - state=BOOT, pc_o=RESET_PC, bubble counter=0;
  - fs1Ready_o=0, flushFS_o=0, icacheCancel_o=0, redirectSrc_o=0.
- States: BOOT, RUN, MISS, BUBBLE.
- BOOT:
  - fs1Ready_o=0.
  - Next cycle goes to RUN with pc_o unchanged; the first fetch is at RESET_PC.
- RUN (fs1Ready_o = ~stall_i & ~ctiQueueFull_i & ~icacheMiss_i). The next PC is chosen by the first matching rule:
  1. recoverEX_i → pc=targetEX_i, src=3, flushFS_o=1, go to BUBBLE with counter=RECOVER_BUBBLE; if RECOVER_BUBBLE=0, stay in RUN. Applies regardless of stall.
  2. recoverID_i → pc=targetID_i, src=2, flushFS_o=1.
  3. stall_i | ctiQueueFull_i → hold pc, src unchanged.
  4. icacheMiss_i → hold pc, go to MISS.
  5. btbTaken_i → pc=btbTarget_i, src=1.
  6. otherwise → pc=pc+32, src=0.
- PC arithmetic:
  - Sequential add wraps modulo 2^SIZE_PC.
  - The low 3 bits of every loaded target are forced to 0.
- MISS:
  - fs1Ready_o=0, pc held.
  - recoverEX_i → icacheCancel_o=1, flushFS_o=1, pc=targetEX_i, src=3, go to BUBBLE (or RUN if RECOVER_BUBBLE=0).
  - recoverID_i is ignored in MISS.
  - icacheFill_i → RUN, pc unchanged; the bundle is refetched next cycle.
  - recoverEX_i and icacheFill_i in the same cycle: recovery wins and icacheCancel_o=1.
- BUBBLE:
  - fs1Ready_o=0; counter decrements each cycle; go to RUN on the cycle the counter reaches 1.
  - A new recoverEX_i reloads pc and counter and pulses flushFS_o.
  - recoverID_i and btbTaken_i are ignored.
- Output timing:
  - pc_o changes only on clock edges.
  - flushFS_o and icacheCancel_o are registered single-cycle pulses, asserted in the cycle after the triggering input.
- Reset asserted mid-MISS or mid-BUBBLE: immediate return to BOOT; no cancel pulse is emitted.

Decomposition:
- Shared package:
  - state encoding: BOOT=2'd0, RUN=2'd1, MISS=2'd2, BUBBLE=2'd3;
  - redirect-source encoding: SRC_SEQ/SRC_BTB/SRC_ID/SRC_EX;
  - FETCH_STRIDE constant (FETCH_BANDWIDTH*INST_BYTES).
- Sub-module next_pc_mux: the combinational priority select plus target alignment. The FSM, counter and registers stay in the top module.

Test Plan:
- Release reset → pc_o=0x2000, fs1Ready_o=0 for 1 cycle. Then 3 free cycles → pc_o=0x2020, 0x2040, 0x2060, redirectSrc_o=0.
- btbTaken_i=1, btbTarget_i=0x3004 at pc 0x2020 → next pc_o=0x3000, src=1. With stall_i=1 held for 2 cycles, pc_o stays 0x3000 and fs1Ready_o=0.
- recoverEX_i with target 0x4000 and recoverID_i with target 0x5000 in the same cycle → pc_o=0x4000, src=3, flushFS_o pulses once, fs1Ready_o=0 for 2 cycles, then 1.
- icacheMiss_i at pc 0x2040 → MISS. icacheFill_i after 5 cycles → RUN with pc_o=0x2040. The next free cycle gives 0x2060.
- In MISS, recoverEX_i (target 0x6000) together with icacheFill_i → icacheCancel_o=1, pc_o=0x6000, state BUBBLE.
- pc=0xFFFF_FFE0 sequential → pc_o=0x0000_0000 (wrap). Asserting reset mid-BUBBLE → pc_o=0x2000, all pulses 0.
